// File: rtl/raster_cursor_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | raster_cursor_gen                                                          |
// | Walks an (x, y) cursor over a runtime-sized W x H window under a           |
// | start/advance/stop handshake and flags row/frame boundaries.               |
// | Optional serpentine walk: define RASTER_CURSOR_SERPENTINE_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module raster_cursor_gen #(
  parameter int X_BITS = 3,
  parameter int Y_BITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
`ifdef RASTER_CURSOR_SERPENTINE_EN
  input  logic              serp,
`endif
  input  logic              advance,
  input  logic [X_BITS:0]   width,
  input  logic [Y_BITS:0]   height,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              busy,
  output logic              row_last,
  output logic              frame_last,
  output logic              frame_done,
  output logic              cfg_err
);

  localparam logic [X_BITS:0] W_MAX = {1'b1, {X_BITS{1'b0}}};
  localparam logic [Y_BITS:0] H_MAX = {1'b1, {Y_BITS{1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t            state;
  logic [X_BITS:0]   w_lat;
  logic [Y_BITS:0]   h_lat;
  logic              cont_lat;
  logic              serp_lat;

  logic              cfg_ok;
  logic              odd_row;
  logic              x_at_end;

`ifdef RASTER_CURSOR_SERPENTINE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serp_lat <= 1'b0;
    end else if (state == IDLE && start && !stop && cfg_ok) begin
      serp_lat <= serp;
    end
  end
`else
  assign serp_lat = 1'b0;
`endif

  assign cfg_ok = (width  != '0) && (width  <= W_MAX) &&
                  (height != '0) && (height <= H_MAX);

  // Odd rows of a serpentine walk run right-to-left and end at column 0.
  assign odd_row    = serp_lat & y[0];
  assign x_at_end   = odd_row ? (x == '0)
                              : ({1'b0, x} == (w_lat - (X_BITS+1)'(1)));
  assign busy       = (state == SCAN);
  assign row_last   = busy & x_at_end;
  assign frame_last = row_last & ({1'b0, y} == (h_lat - (Y_BITS+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      w_lat      <= '0;
      h_lat      <= '0;
      cont_lat   <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_ok) begin
              state    <= SCAN;
              w_lat    <= width;
              h_lat    <= height;
              cont_lat <= cont;
              x        <= '0;
              y        <= '0;
            end else begin
              cfg_err  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (stop) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
          end else if (advance) begin
            if (frame_last) begin
              x          <= '0;
              y          <= '0;
              frame_done <= 1'b1;
              if (!cont_lat) begin
                state <= IDLE;
              end
            end else if (row_last) begin
              // Serpentine keeps x at the turn; raster wraps to column 0.
              y <= y + Y_BITS'(1);
              if (!serp_lat) begin
                x <= '0;
              end
            end else if (odd_row) begin
              x <= x - X_BITS'(1);
            end else begin
              x <= x + X_BITS'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raster_cursor_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_raster_cursor_gen                                                       |
// | Directed self-checking bench for raster_cursor_gen (X_BITS=3, Y_BITS=3).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_raster_cursor_gen;

  localparam int X_BITS = 3;
  localparam int Y_BITS = 3;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              cont;
  logic              serp;
  logic              advance;
  logic [X_BITS:0]   width;
  logic [Y_BITS:0]   height;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic              busy;
  logic              row_last;
  logic              frame_last;
  logic              frame_done;
  logic              cfg_err;

  int errors;
  int checks;

  raster_cursor_gen #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
`ifdef RASTER_CURSOR_SERPENTINE_EN
    .serp       (serp),
`endif
    .advance    (advance),
    .width      (width),
    .height     (height),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .row_last   (row_last),
    .frame_last (frame_last),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey);
    chk({tag, ".x"}, int'(x), ex);
    chk({tag, ".y"}, int'(y), ey);
  endtask

  task automatic begin_scan(input int w, input int h, input logic c, input logic s);
    width  = (X_BITS+1)'(w);
    height = (Y_BITS+1)'(h);
    cont   = c;
    serp   = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    int pos;
    bit done;
    logic adv;
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    cont    = 1'b0;
    serp    = 1'b0;
    advance = 1'b0;
    width   = '0;
    height  = '0;

    // Reset state
    tick();
    chk("rst.busy", int'(busy), 0);
    chk_pos("rst", 0, 0);
    chk("rst.frame_done", int'(frame_done), 0);
    chk("rst.cfg_err", int'(cfg_err), 0);
    chk("rst.row_last", int'(row_last), 0);
    rst_n = 1'b1;
    tick();

    // Single frame 5x3, advance held high
    begin_scan(5, 3, 1'b0, 1'b0);
    chk("f1.busy", int'(busy), 1);
    chk_pos("f1.start", 0, 0);
    advance = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk_pos("f1.walk", i % 5, i / 5);
      chk("f1.row_last", int'(row_last), (i % 5 == 4) ? 1 : 0);
      chk("f1.frame_last", int'(frame_last), (i == 14) ? 1 : 0);
      chk("f1.fd_early", int'(frame_done), 0);
      tick();
    end
    chk("f1.busy_end", int'(busy), 0);
    chk("f1.frame_done", int'(frame_done), 1);
    chk_pos("f1.end", 0, 0);
    advance = 1'b0;
    tick();
    chk("f1.fd_pulse", int'(frame_done), 0);

    // Continuous 8x8, wrap, then stop mid-row at (3,2)
    begin_scan(8, 8, 1'b1, 1'b0);
    advance = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk_pos("c8.walk", i % 8, i / 8);
      tick();
    end
    chk("c8.frame_done", int'(frame_done), 1);
    chk("c8.busy", int'(busy), 1);
    chk_pos("c8.wrap", 0, 0);
    for (int i = 0; i < 19; i++) tick();
    chk_pos("c8.mid", 3, 2);
    chk("c8.fd_mid", int'(frame_done), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    advance = 1'b0;
    chk("stop.busy", int'(busy), 0);
    chk_pos("stop", 0, 0);
    chk("stop.frame_done", int'(frame_done), 0);

    // Illegal configurations
    begin_scan(0, 3, 1'b0, 1'b0);
    chk("w0.cfg_err", int'(cfg_err), 1);
    chk("w0.busy", int'(busy), 0);
    tick();
    chk("w0.cfg_pulse", int'(cfg_err), 0);
    begin_scan(9, 3, 1'b0, 1'b0);
    chk("w9.cfg_err", int'(cfg_err), 1);
    chk("w9.busy", int'(busy), 0);
    begin_scan(4, 0, 1'b0, 1'b0);
    chk("h0.cfg_err", int'(cfg_err), 1);
    chk_pos("h0", 0, 0);
    begin_scan(4, 9, 1'b0, 1'b0);
    chk("h9.cfg_err", int'(cfg_err), 1);

    // start+stop together in IDLE does nothing
    stop = 1'b1;
    begin_scan(4, 4, 1'b0, 1'b0);
    stop = 1'b0;
    chk("ss.busy", int'(busy), 0);
    chk("ss.cfg_err", int'(cfg_err), 0);

    // start during SCAN is ignored
    begin_scan(2, 2, 1'b0, 1'b0);
    advance = 1'b1;
    tick();
    chk_pos("rs.one", 1, 0);
    begin_scan(0, 0, 1'b0, 1'b0);
    chk_pos("rs.ignored", 0, 1);
    chk("rs.busy", int'(busy), 1);
    chk("rs.cfg_err", int'(cfg_err), 0);
    tick();
    tick();
    chk("rs.done_busy", int'(busy), 0);
    chk("rs.done_fd", int'(frame_done), 1);
    advance = 1'b0;

    // Random advance gaps, width/height changed mid-scan
    begin_scan(3, 2, 1'b0, 1'b0);
    pos  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      adv = 1'($urandom_range(0, 1));
      advance = adv;
      if (c == 3) begin
        width  = 4'd7;
        height = 4'd7;
      end
      tick();
      if (adv) pos++;
      if (pos == 6) begin
        chk("gap.busy_end", int'(busy), 0);
        chk("gap.frame_done", int'(frame_done), 1);
        done = 1'b1;
      end else begin
        chk_pos("gap.walk", pos % 3, pos / 3);
        chk("gap.busy", int'(busy), 1);
      end
    end
    chk("gap.finished", int'(done), 1);
    advance = 1'b0;

    // Asynchronous reset mid-frame, then clean restart
    begin_scan(4, 4, 1'b0, 1'b0);
    advance = 1'b1;
    tick();
    tick();
    chk_pos("ar.pre", 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.busy", int'(busy), 0);
    chk_pos("ar.now", 0, 0);
    chk("ar.frame_done", int'(frame_done), 0);
    #1;
    rst_n = 1'b1;
    advance = 1'b0;
    tick();
    begin_scan(4, 4, 1'b0, 1'b0);
    chk("ar.restart_busy", int'(busy), 1);
    chk_pos("ar.restart", 0, 0);
    advance = 1'b1;
    tick();
    chk_pos("ar.step", 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    advance = 1'b0;

`ifdef RASTER_CURSOR_SERPENTINE_EN
    // Serpentine 3x2
    begin
      int sx[6] = '{0, 1, 2, 2, 1, 0};
      int sy[6] = '{0, 0, 0, 1, 1, 1};
      int sr[6] = '{0, 0, 1, 0, 0, 1};
      begin_scan(3, 2, 1'b0, 1'b1);
      advance = 1'b1;
      for (int i = 0; i < 6; i++) begin
        chk_pos("sp.walk", sx[i], sy[i]);
        chk("sp.row_last", int'(row_last), sr[i]);
        chk("sp.frame_last", int'(frame_last), (i == 5) ? 1 : 0);
        tick();
      end
      chk("sp.frame_done", int'(frame_done), 1);
      chk("sp.busy", int'(busy), 0);
    end
    // Serpentine W=1, H=4
    begin_scan(1, 4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_pos("sp1.walk", 0, i);
      chk("sp1.row_last", int'(row_last), 1);
      chk("sp1.frame_last", int'(frame_last), (i == 3) ? 1 : 0);
      tick();
    end
    chk("sp1.frame_done", int'(frame_done), 1);
    advance = 1'b0;
    serp = 1'b0;
`endif

    // Raster W=1, H=2: every position is a row end
    begin_scan(1, 2, 1'b0, 1'b0);
    advance = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk_pos("w1.walk", 0, i);
      chk("w1.row_last", int'(row_last), 1);
      tick();
    end
    chk("w1.frame_done", int'(frame_done), 1);
    advance = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/raster_cursor_gen.md
# raster_cursor_gen

Parametrised cursor/raster address generator for the VGA pixel and character pipeline. It walks an (x, y) cursor over a runtime-sized W×H window under a start/advance/stop handshake. It offers single-frame or continuous operation and flags row and frame boundaries for downstream framebuffer and sprite logic. An optional serpentine (boustrophedon) walk is available.

## Interface
- X_BITS, 3: width of x cursor; max window width 2**X_BITS
- Y_BITS, 3: width of y cursor; max window height 2**Y_BITS
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a scan; accepted only in IDLE
- stop  in  1  abort scan; returns to IDLE
- cont  in  1  continuous mode; sampled on start accept
- serp  in  1  serpentine mode; sampled on start accept (present only with macro)
- advance  in  1  step cursor one position when busy
- width  in  X_BITS+1  window width W; sampled on start accept
- height  in  Y_BITS+1  window height H; sampled on start accept
- x  out  X_BITS  current cursor column
- y  out  Y_BITS  current cursor row
- busy  out  1  scan in progress (state SCAN)
- row_last  out  1  combinational: busy and x is the final column of the current row
- frame_last  out  1  combinational: row_last and y == H-1
- frame_done  out  1  registered one-cycle pulse after the last position is consumed
- cfg_err  out  1  registered one-cycle pulse when start is rejected

## Operation
- States: IDLE, SCAN. Reset → IDLE; x=0, y=0, busy=0, frame_done=0, cfg_err=0; latched W/H/cont/serp cleared to 0.
- IDLE + start + !stop:
  - Config is legal when 1 ≤ W ≤ 2**X_BITS and 1 ≤ H ≤ 2**Y_BITS. Comparisons use X_BITS+1 / Y_BITS+1 bits.
  - Legal config: latch W, H, cont, serp; go to SCAN; x=0, y=0.
  - Illegal config: stay IDLE; pulse cfg_err.
- start while in SCAN is ignored. start and stop together in IDLE are ignored.
- SCAN + stop has priority over advance: go to IDLE; x=0, y=0; no frame_done.
- SCAN + advance + !stop, raster walk:
  - If x < W-1, x+1.
  - Otherwise x=0 and y+1.
- SCAN + advance + !stop, serpentine walk (serp latched 1):
  - Even row: x increments up to W-1.
  - Odd row: x decrements down to 0.
  - At the row end, x holds and y+1.
- row_last, raster: x == W-1.
- row_last, serpentine: (y even and x == W-1) or (y odd and x == 0).
- With W=1, x stays 0 and every position is a row end.
- advance while frame_last:
  - x=0, y=0; frame_done pulses next cycle.
  - cont=1: stay in SCAN.
  - cont=0: go to IDLE.
- SCAN with advance=0: hold position.
- Inputs width, height, cont and serp are ignored outside start accept. Changing them mid-scan has no effect.
- Asynchronous reset mid-scan: immediate return to reset values; no frame_done.

## Timing
- Start accepted at edge N → busy=1, (x,y)=(0,0) visible after edge N. Latency is 1 cycle.
- One position per cycle with advance held high. A full frame takes W·H advance cycles.
- frame_done is high the cycle after the final advance, aligned with (0,0) being presented.
- busy falls on the same edge that raises frame_done (cont=0) or that performs stop.
- The earliest restart is a start in the cycle busy reads 0.
- cfg_err rises 1 cycle after a rejected start; busy stays 0.
- row_last and frame_last are combinational from registered state and latched config. No input → output combinational path exists.

## Configuration
- RASTER_CURSOR_SERPENTINE_EN defined:
  - serp port exists and is latched on start.
  - Serpentine walk is selectable.
- RASTER_CURSOR_SERPENTINE_EN undefined:
  - serp port is absent.
  - Walk is always raster; latched serp is forced to 0 and the serpentine logic is removed.

## Test plan
- Reset, then start with W=5, H=3, cont=0, advance held 1 → x,y follow (0,0)…(4,0),(0,1)…(4,2); row_last high at x=4; frame_last at (4,2); frame_done one pulse after 15 advances; busy drops on the same edge.
- cont=1, W=2**X_BITS=8, H=8 → x=7→0 with y+1; (7,7)→(0,0); busy stays 1; frame_done every 64 advances. Then stop mid-row at (3,2) → IDLE, (0,0), no frame_done.
- start with W=0, W=9 (X_BITS=3), or H=0 → cfg_err pulse, busy=0, x,y unchanged. start+stop in IDLE → nothing happens. start during SCAN → ignored.
- Serpentine (macro on), W=3, H=2 → (0,0),(1,0),(2,0),(2,1),(1,1),(0,1); row_last at (2,0) and (0,1); frame_last at (0,1). Also W=1, H=4 → x stays 0 and row_last is always high.
- Advance gaps with random advance: position holds on 0. Width/height changed mid-scan → no effect. Async rst_n pulse mid-frame → immediate reset values; the next scan starts cleanly from (0,0).
